// File: rtl/core_pkg.sv
// core_pkg: shared core word width, fetch entry type and canonical NOP encoding
package core_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: sync FIFO of fetch_entry_t (push/pop/flush/din in; count/head out), pointers wrap modulo DEPTH
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 3,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  din,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);
    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= inc(wr_ptr);
            end
            if (pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, imem issue (imem_en/imem_pc/imem_instr), redirect flush, {pc,instr} valid/ready output
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_pc,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    logic [XLEN-1:0] fetch_pc, inflight_pc;
    logic            inflight, pop, unused;
    logic [CW-1:0]   count;
    fetch_entry_t    head, cap;
    assign imem_en   = rst_n & ~redirect_valid & ({1'b0, count} + (CW + 1)'(inflight) < (CW + 1)'(FIFO_DEPTH));
    assign imem_pc   = fetch_pc;
    assign out_valid = |count;
    assign pop       = out_valid & out_ready;
    assign cap       = {inflight_pc, imem_instr};
    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign unused    = ^redirect_pc[1:0];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= imem_en;
            if (imem_en) begin
                fetch_pc    <= fetch_pc + XLEN'(4);
                inflight_pc <= fetch_pc;
            end
        end
    end
    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight & ~redirect_valid),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (cap),
        .count (count),
        .head  (head)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random + directed scoreboard bench for fetch_stage against a sequential-PC stream model
module tb_fetch_stage;
    import core_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_en, imem_en_w;
    logic [31:0] imem_pc, imem_pc_w, imem_instr, imem_instr_w;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid, out_valid_w;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_instr, out_pc_w, out_instr_w;
    int          checks = 0, failures = 0, delivered = 0;
    logic [31:0] exp_q[$], exp_w[$];
    logic        hold_v = 1'b0;
    logic [31:0] hold_pc, hold_instr;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_en(imem_en), .imem_pc(imem_pc), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(3)) dut_w (
        .clk(clk), .rst_n(rst_n), .imem_en(imem_en_w), .imem_pc(imem_pc_w), .imem_instr(imem_instr_w),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .out_valid(out_valid_w), .out_ready(1'b1), .out_pc(out_pc_w), .out_instr(out_instr_w)
    );

    function automatic logic [31:0] rom(input logic [31:0] pc);
        case (pc)
            32'h00: return 32'h0050_0613;
            32'h04: return 32'h0060_0693;
            32'h08: return 32'h00D6_0733;
            32'h0C: return 32'h40D6_07B3;
            32'h10: return 32'h00F7_0833;
            32'h14: return INSTR_NOP;
            32'h18: return 32'hFE00_006F;
            default: return (pc * 32'h9E37_79B1) ^ INSTR_NOP;
        endcase
    endfunction

    always @(posedge clk) if (imem_en) imem_instr <= rom(imem_pc);
    always @(posedge clk) if (imem_en_w) imem_instr_w <= rom(imem_pc_w);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (hold_v) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_pc", out_pc, hold_pc);
            chk("hold_instr", out_instr, hold_instr);
        end
        chk("issue_gate", 32'(imem_en & (redirect_valid | ~rst_n)), 32'd0);
        if (rst_n && out_valid && out_ready) begin
            chk("sb_pc", out_pc, exp_q[0]);
            chk("sb_instr", out_instr, rom(exp_q[0]));
            void'(exp_q.pop_front());
            delivered++;
        end
        hold_v     = rst_n & ~redirect_valid & out_valid & ~out_ready;
        hold_pc    = out_pc;
        hold_instr = out_instr;
        if (!rst_n || redirect_valid) begin
            exp_q.delete();
            exp_q.push_back(!rst_n ? 32'h0 : {redirect_pc[31:2], 2'b00});
        end
        while (exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd4);
    end

    always @(negedge clk) begin
        if (rst_n && out_valid_w) begin
            chk("wrap_pc", out_pc_w, exp_w[0]);
            chk("wrap_instr", out_instr_w, rom(exp_w[0]));
            void'(exp_w.pop_front());
        end
        if (!rst_n) begin
            exp_w.delete();
            exp_w.push_back(32'hFFFF_FFFC);
        end
        while (exp_w.size() < 8) exp_w.push_back(exp_w[$] + 32'd4);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          en_cnt, d0;
        logic [31:0] v[3];
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (2) step();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_imem_en", 32'(imem_en), 32'd0);
        chk("rst_imem_pc", imem_pc, 32'd0);
        chk("rst_imem_pc_w", imem_pc_w, 32'hFFFF_FFFC);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            v[k] = 32'(out_valid);
            step();
        end
        chk("lat_c0", v[0], 32'd0);
        chk("lat_c1", v[1], 32'd0);
        chk("lat_c2", v[2], 32'd1);
        d0 = delivered;
        repeat (10) step();
        chk("throughput", 32'(delivered - d0), 32'd10);

        rst_n = 1'b0;
        out_ready = 1'b0;
        step();
        rst_n = 1'b1;
        en_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            en_cnt += int'(imem_en);
            step();
        end
        chk("bp_issue_count", 32'(en_cnt), 32'd3);
        @(negedge clk);
        chk("bp_head_valid", 32'(out_valid), 32'd1);
        chk("bp_head_pc", out_pc, 32'h0);
        chk("bp_head_instr", out_instr, 32'h0050_0613);
        step();
        out_ready = 1'b1;
        d0 = delivered;
        repeat (8) step();
        chk("bp_release", 32'(delivered - d0), 32'd8);

        rst_n = 1'b0;
        out_ready = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h18;
        step();
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rd_issue", 32'(imem_en), 32'd1);
        chk("rd_issue_pc", imem_pc, 32'h18);
        chk("rd_v1", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        chk("rd_v2", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        chk("rd_v3", 32'(out_valid), 32'd1);
        chk("rd_pc", out_pc, 32'h18);
        chk("rd_instr", out_instr, 32'hFE00_006F);
        step();

        repeat (4) step();
        chk("hs_valid", 32'(out_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h6;
        d0 = delivered;
        step();
        redirect_valid = 1'b0;
        repeat (2) step();
        chk("hs_once", 32'(delivered - d0), 32'd1);
        @(negedge clk);
        chk("hs_next_valid", 32'(out_valid), 32'd1);
        chk("hs_next_pc", out_pc, 32'h4);
        step();

        out_ready = 1'b0;
        repeat (6) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            v[k] = 32'(out_valid);
            if (k == 2) chk("rr_pc", out_pc, 32'h0);
            step();
        end
        chk("rr_c0", v[0], 32'd0);
        chk("rr_c1", v[1], 32'd0);
        chk("rr_c2", v[2], 32'd1);

        d0 = delivered;
        repeat (2000) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 32'($urandom_range(0, 63));
            rst_n          = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        chk("rand_progress", 32'((delivered - d0) > 500), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end for one core. Owns the PC, drives the synchronous 1-cycle-latency instruction ROM (`en`/`pc` in, `instr` out one clock later), and delivers `{pc, instr}` pairs to decode over a valid/ready handshake. It sits directly upstream of the instruction memory and downstream of the execute-stage redirect (branch/jump) path. Decode backpressure never combinationally reaches the memory enable.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `FIFO_DEPTH`, 3, output buffer entries; legal values ≥2; full throughput requires ≥3
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `imem_en`  out  1  fetch request; ROM samples `imem_pc` at this edge
- `imem_pc`  out  32  fetch address (word-aligned)
- `imem_instr`  in  32  ROM data, valid the cycle after `imem_en`=1; holds while `imem_en`=0
- `redirect_valid`  in  1  flush and restart fetch
- `redirect_pc`  in  32  restart address; bits [1:0] ignored (treated as 00)
- `out_valid`  out  1  buffer head valid
- `out_ready`  in  1  decode accepts head
- `out_pc`  out  32  PC of head entry
- `out_instr`  out  32  instruction of head entry

## Operation
- State: `fetch_pc` (next address to issue), `inflight` bit plus `inflight_pc` (request issued last cycle), and a FIFO of `{pc, instr}` with occupancy `count`.
- Issue: `imem_en = rst_n & ~redirect_valid & (count + inflight < FIFO_DEPTH)`; `imem_pc = fetch_pc`. On issue, `fetch_pc += 4` (modulo 2^32), `inflight <= 1`, `inflight_pc <= fetch_pc`; otherwise `inflight <= 0`.
- Capture: when `inflight`=1 and no redirect, push `{inflight_pc, imem_instr}`. The credit rule guarantees no overflow. Never push without `inflight`.
- Pop: on `out_valid & out_ready`.
- Simultaneous push and pop: `count` is unchanged. Pop from a 1-entry FIFO with a push leaves the new entry at the head on the next cycle.
- Redirect (highest priority): `count <= 0`, `inflight <= 0` (the in-flight word is discarded), `fetch_pc <= {redirect_pc[31:2], 2'b00}`, no issue this cycle. A handshake in the same cycle counts as delivered; all other entries are dropped.
- Reset (`rst_n`=0 at an edge, including mid-operation): `fetch_pc <= RESET_PC`, `count <= 0`, `inflight <= 0`, FIFO storage cleared.
- Output reset values: `out_valid`=0, `out_pc`=0, `out_instr`=0, `imem_en`=0, `imem_pc`=`RESET_PC`.

## Timing
- Issue at cycle t → capture at end of t+1 → `out_valid` in cycle t+2.
- First `out_valid` is 2 cycles after the first cycle with `rst_n`=1.
- Redirect at cycle t: issue at t+1, `out_valid` with `redirect_pc` at t+3.
- Sustains 1 instruction/cycle with `out_ready`=1 held (FIFO_DEPTH ≥ 3).
- `out_ready` low: at most `FIFO_DEPTH` words are held. Issue stops combinationally from registered `count`/`inflight` only.
- `out_*` come straight from the FIFO head registers: stable while `out_valid & ~out_ready`, with no combinational input→output path.
- `count` width is `$clog2(FIFO_DEPTH+1)`.

## Structure
- Shared package `core_pkg`:
  - `XLEN` = 32
  - `typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t`
  - `INSTR_NOP` = 32'h0000_0013
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`.
  - Parameter `DEPTH`.
  - Ports: push/pop/flush, `count`, head data.
  - Pointers wrap modulo `DEPTH` (non-power-of-two depth supported).
- `fetch_stage` holds the PC, in-flight tracking and issue logic. Target 150–250 lines total.

## Test plan
- Reset release with `out_ready`=1 against core-1 ROM → `out_valid` at cycle 2; pairs (0x0, 0x00500613), (0x4, 0x00600693), … one per cycle; pc 0x18 gives 0xFE00006F.
- `out_ready`=0 from reset → exactly 3 `imem_en` pulses (pc 0, 4, 8), then `imem_en`=0. Head stays (0x0, 0x00500613). On release, pcs 0, 4, 8, 0xC are contiguous with no gap or duplicate.
- Redirect to 0x18 with FIFO holding 2 entries and 1 in flight → next delivered pc 0x18, instr 0xFE00006F, 3 cycles later; no stale pc delivered.
- Redirect to 0x0000_0006 in the same cycle as a handshake → handshaked entry counted once; next delivered pc 0x4.
- `RESET_PC`=0xFFFF_FFFC → delivered pcs 0xFFFF_FFFC then 0x0000_0000 (wrap).
- `rst_n` low for one cycle with FIFO full → `out_valid`=0 the next cycle; fetch restarts at `RESET_PC` with the 2-cycle latency.
